// File: rtl/blake2_pkg.sv
// Shared BLAKE2s definitions: block geometry, counter width, bank and message state encodings.
package blake2_pkg;
  localparam int BLOCK_BYTES = 64;
  localparam int T_W         = 64;
  localparam int POS_W       = $clog2(BLOCK_BYTES);
  localparam int BLK_W       = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_FULL} bank_state_e;
  typedef enum logic [1:0] {MSG_IDLE, MSG_ACTIVE, MSG_DONE}     msg_state_e;
endpackage

// File: rtl/msg_block_buffer_if.sv
// Byte-stream input and block-output handshake of the message block buffer.
interface msg_block_buffer_if;
  import blake2_pkg::*;
  logic             msg_start_i;
  logic [T_W-1:0]   ll_i;
  logic             data_v_i;
  logic [7:0]       data_i;
  logic [POS_W-1:0] data_idx_i;
  logic             blk_v_o;
  logic             blk_ready_i;
  logic [BLK_W-1:0] blk_o;
  logic [T_W-1:0]   blk_t_o;
  logic             blk_last_o;
  logic             err_o;

  modport slave (
    input  msg_start_i, ll_i, data_v_i, data_i, data_idx_i, blk_ready_i,
    output blk_v_o, blk_o, blk_t_o, blk_last_o, err_o
  );
  modport master (
    output msg_start_i, ll_i, data_v_i, data_i, data_idx_i, blk_ready_i,
    input  blk_v_o, blk_o, blk_t_o, blk_last_o, err_o
  );
endinterface

// File: rtl/msg_block_bank.sv
// One 64-byte message bank: byte write at a position, zero-on-clear, t/last tag set at close.
// Clear is applied first so a write/close in the same cycle lands in the freshly zeroed bank.
module msg_block_bank
  import blake2_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [POS_W-1:0] wr_pos_i,
  input  logic [7:0]       wr_data_i,
  input  logic             close_i,
  input  logic [T_W-1:0]   close_t_i,
  input  logic             close_last_i,
  output bank_state_e      state_o,
  output logic [BLK_W-1:0] data_o,
  output logic [T_W-1:0]   t_o,
  output logic             last_o
);
  bank_state_e      state_q, state_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             last_q, last_d;

  // Next bank contents: clear, then byte write, then close tagging.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    t_d     = t_q;
    last_d  = last_q;
    if (clr_i) begin
      state_d = BANK_FREE;
      data_d  = '0;
      t_d     = '0;
      last_d  = 1'b0;
    end
    if (wr_i) begin
      data_d[{wr_pos_i, 3'b000} +: 8] = wr_data_i;
      state_d = BANK_FILLING;
    end
    if (close_i) begin
      state_d = BANK_FULL;
      t_d     = close_t_i;
      last_d  = close_last_i;
    end
  end

  // Bank registers with synchronous reset to an empty, zeroed bank.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= BANK_FREE;
      data_q  <= '0;
      t_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      t_q     <= t_d;
      last_q  <= last_d;
    end
  end

  assign state_o = state_q;
  assign data_o  = data_q;
  assign t_o     = t_q;
  assign last_o  = last_q;
endmodule

// File: rtl/msg_block_buffer.sv
// Ping-pong message block buffer: assembles the byte stream into 64-byte blocks,
// tracks the byte counter t, flags the final block and hands blocks out on valid/ready.
// Optional macro MSG_BLOCK_BUFFER_IDX_CHECK_EN: flag an error when the upstream byte
// index disagrees with the internal fill position.
module msg_block_buffer
  import blake2_pkg::*;
(
  input  logic               clk,
  input  logic               nreset,
  msg_block_buffer_if.slave  bus
);
  msg_state_e       msg_q, msg_d;
  logic             fill_q, fill_d, rd_q, rd_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [T_W-1:0]   t_q, t_d, ll_q, ll_d;
  logic             err_q, err_d;

  bank_state_e      bank_state [2];
  logic [BLK_W-1:0] bank_data  [2];
  logic [T_W-1:0]   bank_t     [2];
  logic             bank_last  [2];

  logic [1:0]       clr, wr, close;
  logic [POS_W-1:0] wr_pos;
  logic [T_W-1:0]   close_t, t_inc;
  logic             close_last, fill_full, blk_v, accept;

  // Message control: start/abort, accept, byte write and block close decisions.
  always_comb begin
    msg_d      = msg_q;
    fill_d     = fill_q;
    rd_d       = rd_q;
    pos_d      = pos_q;
    t_d        = t_q;
    ll_d       = ll_q;
    err_d      = err_q;
    clr        = '0;
    wr         = '0;
    close      = '0;
    close_t    = '0;
    close_last = 1'b0;
    wr_pos     = pos_q;
    t_inc      = '0;
    fill_full  = (bank_state[fill_q] == BANK_FULL);
    blk_v      = (bank_state[rd_q] == BANK_FULL);
    // a start wipes both banks, so a concurrent ready accepts nothing
    accept     = blk_v & bus.blk_ready_i & ~bus.msg_start_i;

    if (accept) begin
      clr[rd_q] = 1'b1;
      rd_d      = ~rd_q;
    end

    if (bus.msg_start_i) begin
      clr       = 2'b11;
      msg_d     = MSG_ACTIVE;
      fill_d    = 1'b0;
      rd_d      = 1'b0;
      pos_d     = '0;
      t_d       = '0;
      ll_d      = bus.ll_i;
      err_d     = 1'b0;
      fill_full = 1'b0;
      // empty message: a single all-zero final block
      if (bus.ll_i == '0) begin
        close[0]   = 1'b1;
        close_last = 1'b1;
        msg_d      = MSG_DONE;
        fill_d     = 1'b1;
      end
    end

    // a byte concurrent with start is evaluated against the new message
    if (bus.data_v_i) begin
      if (msg_d == MSG_ACTIVE && !fill_full) begin
        wr_pos     = pos_d;
        wr[fill_d] = 1'b1;
        t_inc      = t_d + 1'b1;
        t_d        = t_inc;
`ifdef MSG_BLOCK_BUFFER_IDX_CHECK_EN
        if (bus.data_idx_i != wr_pos) err_d = 1'b1;
`endif
        if ((&wr_pos) || t_inc == ll_d) begin
          close[fill_d] = 1'b1;
          close_t       = t_inc;
          close_last    = (t_inc == ll_d);
          if (t_inc == ll_d) msg_d = MSG_DONE;
          fill_d        = ~fill_d;
          pos_d         = '0;
        end else begin
          pos_d = wr_pos + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Control registers with synchronous reset; no message is open after reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      msg_q  <= MSG_DONE;
      fill_q <= 1'b0;
      rd_q   <= 1'b0;
      pos_q  <= '0;
      t_q    <= '0;
      ll_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      msg_q  <= msg_d;
      fill_q <= fill_d;
      rd_q   <= rd_d;
      pos_q  <= pos_d;
      t_q    <= t_d;
      ll_q   <= ll_d;
      err_q  <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    msg_block_bank u_bank (
      .clk          (clk),
      .nreset       (nreset),
      .clr_i        (clr[b]),
      .wr_i         (wr[b]),
      .wr_pos_i     (wr_pos),
      .wr_data_i    (bus.data_i),
      .close_i      (close[b]),
      .close_t_i    (close_t),
      .close_last_i (close_last),
      .state_o      (bank_state[b]),
      .data_o       (bank_data[b]),
      .t_o          (bank_t[b]),
      .last_o       (bank_last[b])
    );
  end

  assign bus.blk_v_o    = blk_v;
  assign bus.blk_o      = bank_data[rd_q];
  assign bus.blk_t_o    = bank_t[rd_q];
  assign bus.blk_last_o = bank_last[rd_q];
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_msg_block_buffer.sv
// Self-checking bench for msg_block_buffer: directed scenarios plus randomized traffic
// compared each cycle against a queue-based model of pending blocks.
module tb_msg_block_buffer;
  import blake2_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  msg_block_buffer_if bus();
  msg_block_buffer dut (.clk(clk), .nreset(nreset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  t;
    bit           last;
  } blk_s;

  // model: closed blocks awaiting acceptance, plus the block being assembled
  blk_s         mq[$];
  logic [511:0] m_cur;
  int           m_pos;
  logic [63:0]  m_t, m_ll;
  int           m_st;      // 1 = message open, 2 = no message open
  bit           m_err;
  int           idx_bias = 0;

  task automatic model_step(input bit st, input logic [63:0] ll, input bit dv,
                            input logic [7:0] d, input logic [5:0] idx, input bit rdy);
    bit acc, full;
    blk_s b;
    if (!nreset) begin
      mq.delete(); m_cur = '0; m_pos = 0; m_t = '0; m_ll = '0; m_st = 2; m_err = 0;
      return;
    end
    acc = (mq.size() > 0) && rdy && !st;
    if (st) begin
      mq.delete(); m_cur = '0; m_pos = 0; m_t = '0; m_ll = ll; m_st = 1; m_err = 0;
      if (ll == 0) begin
        b.data = '0; b.t = '0; b.last = 1; mq.push_back(b); m_st = 2;
      end
    end
    full = (mq.size() == 2);
    if (acc) void'(mq.pop_front());
    if (dv) begin
      if (m_st == 1 && !full) begin
`ifdef MSG_BLOCK_BUFFER_IDX_CHECK_EN
        if (int'(idx) != m_pos) m_err = 1;
`else
        if (idx === 6'bx) m_err = m_err;
`endif
        m_cur[m_pos*8 +: 8] = d;
        m_pos++;
        m_t = m_t + 1;
        if (m_pos == 64 || m_t == m_ll) begin
          b.data = m_cur; b.t = m_t; b.last = (m_t == m_ll);
          mq.push_back(b);
          if (b.last) m_st = 2;
          m_cur = '0; m_pos = 0;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  // one clock: drive inputs, advance the model, sample 1 time unit after the edge
  task automatic tick(input bit st, input logic [63:0] ll, input bit dv,
                      input logic [7:0] d, input bit rdy);
    logic [5:0] idx;
    idx = st ? 6'd0 : 6'(m_pos + idx_bias);
    bus.msg_start_i = st; bus.ll_i = ll; bus.data_v_i = dv; bus.data_i = d;
    bus.data_idx_i = idx; bus.blk_ready_i = rdy;
    model_step(st, ll, dv, d, idx, rdy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nreset = 0;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    nreset = 1;
    checks++; if (bus.blk_v_o !== 1'b0) begin errors++; $display("FAIL reset_blk_v got=%b exp=0", bus.blk_v_o); end
    checks++; if (bus.blk_o !== '0) begin errors++; $display("FAIL reset_blk_o got=%h exp=0", bus.blk_o); end
    checks++; if (bus.blk_t_o !== 64'd0) begin errors++; $display("FAIL reset_blk_t got=%0d exp=0", bus.blk_t_o); end
    checks++; if (bus.blk_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", bus.blk_last_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
    // no message is open after reset, so a byte is a protocol error
    tick(0, 0, 1, 8'hAA, 0);
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL reset_done_byte_err got=%b exp=1", bus.err_o); end
  endtask

  task automatic test_single_block();
    logic [511:0] exp;
    tick(1, 64, 0, 0, 0);
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL single_start_clears_err got=%b exp=0", bus.err_o); end
    for (int p = 0; p < 64; p++) begin
      exp[p*8 +: 8] = 8'(p);
      if (p == 63) begin
        checks++; if (bus.blk_v_o !== 1'b0) begin errors++; $display("FAIL single_early_v got=%b exp=0", bus.blk_v_o); end
      end
      tick(0, 0, 1, 8'(p), 0);
    end
    checks++; if (bus.blk_v_o !== 1'b1) begin errors++; $display("FAIL single_v got=%b exp=1", bus.blk_v_o); end
    checks++; if (bus.blk_o !== exp) begin errors++; $display("FAIL single_data got=%h exp=%h", bus.blk_o, exp); end
    checks++; if (bus.blk_t_o !== 64'd64) begin errors++; $display("FAIL single_t got=%0d exp=64", bus.blk_t_o); end
    checks++; if (bus.blk_last_o !== 1'b1) begin errors++; $display("FAIL single_last got=%b exp=1", bus.blk_last_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", bus.err_o); end
    tick(0, 0, 0, 0, 1);
    checks++; if (bus.blk_v_o !== 1'b0) begin errors++; $display("FAIL single_after_accept_v got=%b exp=0", bus.blk_v_o); end
  endtask

  task automatic test_backpressure();
    blk_s got[$];
    blk_s b;
    logic [7:0] bytes [130];
    logic [511:0] exp0;
    bit rdy;
    tick(1, 130, 0, 0, 0);
    for (int i = 0; i < 130; i++) begin
      bytes[i] = 8'($urandom);
      rdy = (i >= 100);
      if (bus.blk_v_o && rdy) begin b.data = bus.blk_o; b.t = bus.blk_t_o; b.last = bus.blk_last_o; got.push_back(b); end
      tick(0, 0, 1, bytes[i], rdy);
    end
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      if (bus.blk_v_o) begin b.data = bus.blk_o; b.t = bus.blk_t_o; b.last = bus.blk_last_o; got.push_back(b); end
      tick(0, 0, 0, 0, 1);
    end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL bp_err got=%b exp=0", bus.err_o); end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL bp_block_count got=%0d exp=3", got.size());
    end else begin
      for (int p = 0; p < 64; p++) exp0[p*8 +: 8] = bytes[p];
      checks++; if (got[0].data !== exp0) begin errors++; $display("FAIL bp_data0 got=%h exp=%h", got[0].data, exp0); end
      checks++; if (got[0].t !== 64'd64 || got[0].last !== 1'b0) begin errors++; $display("FAIL bp_blk0 t=%0d last=%b exp t=64 last=0", got[0].t, got[0].last); end
      checks++; if (got[1].t !== 64'd128 || got[1].last !== 1'b0) begin errors++; $display("FAIL bp_blk1 t=%0d last=%b exp t=128 last=0", got[1].t, got[1].last); end
      checks++; if (got[2].t !== 64'd130 || got[2].last !== 1'b1) begin errors++; $display("FAIL bp_blk2 t=%0d last=%b exp t=130 last=1", got[2].t, got[2].last); end
      checks++; if (got[2].data[15:0] !== {bytes[129], bytes[128]}) begin errors++; $display("FAIL bp_blk2_head got=%h exp=%h", got[2].data[15:0], {bytes[129], bytes[128]}); end
      checks++; if (got[2].data[511:16] !== '0) begin errors++; $display("FAIL bp_blk2_pad got=%h exp=0", got[2].data[511:16]); end
    end
  endtask

  task automatic test_overflow();
    tick(1, 200, 0, 0, 0);
    for (int i = 0; i < 128; i++) tick(0, 0, 1, 8'($urandom), 0);
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ovf_err_before got=%b exp=0", bus.err_o); end
    tick(0, 0, 1, 8'h55, 0);
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", bus.err_o); end
    checks++; if (bus.blk_v_o !== 1'b1) begin errors++; $display("FAIL ovf_v got=%b exp=1", bus.blk_v_o); end
    checks++; if (bus.blk_t_o !== 64'd64) begin errors++; $display("FAIL ovf_t got=%0d exp=64", bus.blk_t_o); end
    checks++; if (bus.blk_last_o !== 1'b0) begin errors++; $display("FAIL ovf_last got=%b exp=0", bus.blk_last_o); end
  endtask

  task automatic test_zero_len();
    tick(1, 0, 0, 0, 0);
    checks++; if (bus.blk_v_o !== 1'b1) begin errors++; $display("FAIL zero_v got=%b exp=1", bus.blk_v_o); end
    checks++; if (bus.blk_o !== '0) begin errors++; $display("FAIL zero_data got=%h exp=0", bus.blk_o); end
    checks++; if (bus.blk_t_o !== 64'd0) begin errors++; $display("FAIL zero_t got=%0d exp=0", bus.blk_t_o); end
    checks++; if (bus.blk_last_o !== 1'b1) begin errors++; $display("FAIL zero_last got=%b exp=1", bus.blk_last_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL zero_err_clear got=%b exp=0", bus.err_o); end
    tick(0, 0, 1, 8'h12, 0);
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL zero_byte_err got=%b exp=1", bus.err_o); end
    tick(0, 0, 0, 0, 1);
    checks++; if (bus.blk_v_o !== 1'b0) begin errors++; $display("FAIL zero_accept_v got=%b exp=0", bus.blk_v_o); end
  endtask

  task automatic test_abort();
    logic [511:0] exp;
    tick(1, 128, 0, 0, 0);
    for (int i = 0; i < 70; i++) tick(0, 0, 1, 8'($urandom), 0);
    checks++; if (bus.blk_v_o !== 1'b1) begin errors++; $display("FAIL abort_pending_v got=%b exp=1", bus.blk_v_o); end
    nreset = 0;
    tick(0, 0, 0, 0, 0);
    nreset = 1;
    checks++; if (bus.blk_v_o !== 1'b0) begin errors++; $display("FAIL abort_reset_v got=%b exp=0", bus.blk_v_o); end
    tick(1, 64, 0, 0, 0);
    for (int p = 0; p < 64; p++) begin
      exp[p*8 +: 8] = 8'(p) ^ 8'hA5;
      tick(0, 0, 1, 8'(p) ^ 8'hA5, 0);
    end
    checks++; if (bus.blk_v_o !== 1'b1 || bus.blk_t_o !== 64'd64 || bus.blk_last_o !== 1'b1)
      begin errors++; $display("FAIL abort_new_blk v=%b t=%0d last=%b exp v=1 t=64 last=1", bus.blk_v_o, bus.blk_t_o, bus.blk_last_o); end
    checks++; if (bus.blk_o !== exp) begin errors++; $display("FAIL abort_new_data got=%h exp=%h", bus.blk_o, exp); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL abort_new_err got=%b exp=0", bus.err_o); end
    // a new start discards the pending block
    tick(1, 100, 0, 0, 0);
    checks++; if (bus.blk_v_o !== 1'b0) begin errors++; $display("FAIL abort_start_v got=%b exp=0", bus.blk_v_o); end
  endtask

  task automatic test_idx();
    tick(1, 64, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 8'(i), 0);
    idx_bias = 1;
    tick(0, 0, 1, 8'h44, 0);
    idx_bias = 0;
`ifdef MSG_BLOCK_BUFFER_IDX_CHECK_EN
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL idx_mismatch_err got=%b exp=1", bus.err_o); end
`else
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL idx_ignored_err got=%b exp=0", bus.err_o); end
`endif
  endtask

  task automatic test_random();
    int ll, rbias, dbias;
    bit dv, rdy;
    for (int m = 0; m < 8; m++) begin
      ll    = $urandom_range(1, 300);
      rbias = $urandom_range(1, 9);
      dbias = $urandom_range(1, 3);
      dv    = $urandom_range(0, 1);
      tick(1, 64'(ll), dv, 8'($urandom), 0);
      for (int c = 0; c < 900; c++) begin
        if (m_st == 2 && mq.size() == 0 && c > 4) break;
        dv  = ($urandom_range(0, 3) < dbias) && (m_st == 1 || $urandom_range(0, 15) == 0);
        rdy = ($urandom_range(0, 9) < rbias);
        tick(0, 0, dv, 8'($urandom), rdy);
        checks++;
        if (bus.blk_v_o !== (mq.size() > 0)) begin
          errors++; $display("FAIL rnd_v msg=%0d cyc=%0d got=%b exp=%b", m, c, bus.blk_v_o, mq.size() > 0);
        end else if (mq.size() > 0) begin
          checks++;
          if (bus.blk_o !== mq[0].data || bus.blk_t_o !== mq[0].t || bus.blk_last_o !== mq[0].last) begin
            errors++; $display("FAIL rnd_blk msg=%0d cyc=%0d t=%0d last=%b exp t=%0d last=%b data=%h exp=%h",
                               m, c, bus.blk_t_o, bus.blk_last_o, mq[0].t, mq[0].last, bus.blk_o, mq[0].data);
          end
        end
        checks++;
        if (bus.err_o !== m_err) begin errors++; $display("FAIL rnd_err msg=%0d cyc=%0d got=%b exp=%b", m, c, bus.err_o, m_err); end
      end
    end
  endtask

  initial begin
    bus.msg_start_i = 0; bus.ll_i = '0; bus.data_v_i = 0; bus.data_i = '0;
    bus.data_idx_i = '0; bus.blk_ready_i = 0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_abort();
    test_idx();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
